// File: rtl/instr_fetch_if.sv
// instr_fetch_if: request/acknowledge bus between the fetch stage and instruction memory
interface instr_fetch_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage with imem req/ack handshake and a held instruction slot toward decode
module instr_fetch #(
    parameter int          ADDR_W  = 10,
    parameter int          TIMEOUT = 15,
    parameter logic [31:0] NOP     = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc,
    output logic          pc_en,
    instr_fetch_if.master imem,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [31:0]   pc_out,
    output logic [5:0]    opcode,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    rd,
    output logic [4:0]    shamt,
    output logic [5:0]    funct,
    output logic [15:0]   imm16,
    output logic [25:0]   imm26,
    output logic          fetch_err,
    output logic [31:0]   fetch_cnt
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [7:0] tmo_cnt;
    logic       misal;
    logic       in_req;
    logic       accept;
    logic       tmo_hit;
    logic       take;

    // a misaligned PC never raises req; the FSM drops straight into ERR instead
    assign misal   = |pc[1:0];
    assign in_req  = (state == REQ) && !misal;
    assign accept  = in_req && imem.ack;
    assign tmo_hit = in_req && !imem.ack && (tmo_cnt == 8'(TIMEOUT - 1));
    assign take    = (state == HOLD) && instr_valid && instr_ready;

    assign imem.req  = in_req;
    assign imem.addr = pc[ADDR_W+1:2];
    assign pc_en     = take;
    assign fetch_err = state == ERR;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
    assign imm26  = instr[25:0];

    // next state: an ack beats a simultaneous timeout; ERR only leaves through reset
    always_comb begin
        state_nx = (state == IDLE) ? REQ :
                   (state == REQ)  ? (misal ? ERR : accept ? HOLD : tmo_hit ? ERR : REQ) :
                   (state == HOLD) ? (instr_ready ? REQ : HOLD) :
                   ERR;
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // cycles spent waiting for an ack; idles at zero outside an outstanding request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_cnt <= '0;
        else        tmo_cnt <= (in_req && !imem.ack && !tmo_hit) ? tmo_cnt + 8'd1 : '0;
    end

    // instruction slot: fill on ack, drain to NOP when decode consumes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_valid <= 1'b0;
            instr       <= NOP;
            pc_out      <= '0;
            fetch_cnt   <= '0;
        end else if (accept) begin
            instr_valid <= 1'b1;
            instr       <= imem.rdata;
            pc_out      <= pc;
        end else if (take) begin
            instr_valid <= 1'b0;
            instr       <= NOP;
            fetch_cnt   <= fetch_cnt + 32'd1;
        end
    end
endmodule
